nes_controller_emulator: RTL and testbench



---
 rtl/nes_controller_emulator_if.sv | 22 ++
 rtl/nes_controller_emulator.sv | 91 +++++++++
 tb/tb_nes_controller_emulator.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/nes_controller_emulator_if.sv
// nes_controller_emulator_if: pad-side bus between the console/harness (master) and the pad emulator (slave)
interface nes_controller_emulator_if #(
    parameter int NUM_BITS = 8
);
    logic [NUM_BITS-1:0] buttons;
    logic [NUM_BITS-1:0] turbo_mask;
    logic                nes_latch;
    logic                nes_clk;
    logic                nes_data;
    logic                busy;
    logic                frame_done;

    modport master (
        output buttons, turbo_mask, nes_latch, nes_clk,
        input  nes_data, busy, frame_done
    );

    modport slave (
        input  buttons, turbo_mask, nes_latch, nes_clk,
        output nes_data, busy, frame_done
    );
endinterface

// File: rtl/nes_controller_emulator.sv
// nes_controller_emulator: responder end of the NES/SNES serial pad protocol
// Optional auto-fire on turbo_mask buttons when TURBO_EN is defined.
module nes_controller_emulator #(
    parameter int NUM_BITS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input logic                     clk,
    input logic                     reset,
    nes_controller_emulator_if.slave bus
);
    localparam int CW = $clog2(NUM_BITS) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t                 state, state_n;
    logic [NUM_BITS-1:0]    sr, sr_n, eff;
    logic [CW-1:0]          cnt, cnt_n;
    logic [SYNC_STAGES-1:0] latch_sync, clk_sync;
    logic                   latch_d, clk_d;
    logic                   latch_s, clk_s, clk_rise, latch_fall;
    logic                   frame_done_n, nes_data_n;

    assign latch_s    = latch_sync[SYNC_STAGES-1];
    assign clk_s      = clk_sync[SYNC_STAGES-1];
    assign clk_rise   = clk_s & ~clk_d;
    assign latch_fall = ~latch_s & latch_d;
    assign bus.busy   = (state == LOAD) || (state == SHIFT);

`ifdef TURBO_EN
    logic [1:0] fc;

    // Masked buttons read pressed only while fc[1] is set: 2 frames off, 2 on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) fc <= '0;
        else if (bus.frame_done) fc <= fc + 2'd1;
    end

    assign eff = bus.buttons & ~(bus.turbo_mask & {NUM_BITS{~fc[1]}});
`else
    logic unused;
    assign unused = ^bus.turbo_mask;
    assign eff    = bus.buttons;
`endif

    // Latch level has priority over everything, so a coincident nes_clk edge never shifts.
    always_comb begin
        state_n      = state;
        sr_n         = sr;
        cnt_n        = cnt;
        frame_done_n = 1'b0;
        if (latch_s) begin
            state_n = LOAD;
            sr_n    = eff;
            cnt_n   = '0;
        end else if (state == LOAD && latch_fall) begin
            state_n = SHIFT;
        end else if (state == SHIFT && clk_rise) begin
            sr_n  = {1'b0, sr[NUM_BITS-1:1]};
            cnt_n = cnt + 1'b1;
            if (cnt_n == CW'(NUM_BITS)) begin
                state_n      = DONE;
                frame_done_n = 1'b1;
            end
        end
        nes_data_n = (state == LOAD || state == SHIFT) ? ~sr[0] : 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            latch_sync     <= '0;
            clk_sync       <= '0;
            latch_d        <= 1'b0;
            clk_d          <= 1'b0;
            state          <= IDLE;
            sr             <= '0;
            cnt            <= '0;
            bus.nes_data   <= 1'b1;
            bus.frame_done <= 1'b0;
        end else begin
            latch_sync     <= {latch_sync[SYNC_STAGES-2:0], bus.nes_latch};
            clk_sync       <= {clk_sync[SYNC_STAGES-2:0], bus.nes_clk};
            latch_d        <= latch_s;
            clk_d          <= clk_s;
            state          <= state_n;
            sr             <= sr_n;
            cnt            <= cnt_n;
            bus.nes_data   <= nes_data_n;
            bus.frame_done <= frame_done_n;
        end
    end
endmodule

// File: tb/tb_nes_controller_emulator.sv
// tb_nes_controller_emulator: directed scoreboard bench for the NES pad emulator
module tb_nes_controller_emulator;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    nes_controller_emulator_if #(.NUM_BITS(8)) bus();
    nes_controller_emulator #(.NUM_BITS(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int   n_assert = 0;
    int   n_fail   = 0;
    logic exp_q[$];
    int   fd_count = 0;
    int   fd_long  = 0;
    logic fd_prev  = 1'b0;
    int   fd0;

    always @(negedge clk) begin
        if (bus.frame_done) fd_count++;
        if (bus.frame_done && fd_prev) fd_long++;
        fd_prev = bus.frame_done;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pop_check(input string tag);
        logic e;
        if (exp_q.size() == 0) begin
            check({tag, "_qempty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check(tag, {31'd0, bus.nes_data}, {31'd0, e});
        end
    endtask

    task automatic push_frame(input logic [7:0] b);
        for (int i = 0; i < 8; i++) exp_q.push_back(~b[i]);
        exp_q.push_back(1'b1);
    endtask

    task automatic pulse_latch(input logic [7:0] b);
        bus.buttons   = b;
        bus.nes_latch = 1'b1;
        cyc(6);
        bus.nes_latch = 1'b0;
        cyc(6);
    endtask

    task automatic pulse_clk();
        bus.nes_clk = 1'b1;
        cyc(6);
        bus.nes_clk = 1'b0;
        cyc(6);
    endtask

    task automatic read_frame(input string tag);
        pop_check({tag, "_b0"});
        for (int i = 1; i <= 8; i++) begin
            pulse_clk();
            pop_check($sformatf("%s_b%0d", tag, i));
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus.buttons    = '0;
        bus.turbo_mask = '0;
        bus.nes_latch  = 1'b0;
        bus.nes_clk    = 1'b0;
        cyc(3);
        reset = 1'b0;
        cyc(1);
        check("rst_data", {31'd0, bus.nes_data}, 32'd1);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_fd", {31'd0, bus.frame_done}, 32'd0);
        cyc(1000);
        check("idle_data", {31'd0, bus.nes_data}, 32'd1);
        check("idle_busy", {31'd0, bus.busy}, 32'd0);
        check("idle_fd_count", fd_count, 32'd0);

        // Basic frame 8'h85
        push_frame(8'h85);
        pulse_latch(8'h85);
        check("f85_busy", {31'd0, bus.busy}, 32'd1);
        fd0 = fd_count;
        pop_check("f85_b0");
        for (int i = 1; i < 8; i++) begin
            pulse_clk();
            pop_check($sformatf("f85_b%0d", i));
        end
        check("f85_fd_early", fd_count, fd0);
        pulse_clk();
        pop_check("f85_end");
        check("f85_fd_once", fd_count, fd0 + 1);
        check("f85_fd_width", fd_long, 32'd0);
        check("f85_busy_end", {31'd0, bus.busy}, 32'd0);
        pulse_clk();
        check("done_ignore_clk_data", {31'd0, bus.nes_data}, 32'd1);
        check("done_ignore_clk_fd", fd_count, fd0 + 1);

        // Abort mid-frame, then restart from bit0
        fd0 = fd_count;
        pulse_latch(8'h00);
        repeat (3) pulse_clk();
        pulse_latch(8'h01);
        check("abort_no_fd", fd_count, fd0);
        check("abort_bit0", {31'd0, bus.nes_data}, 32'd0);

        // LOAD follows buttons live; value held from last latch-high cycle
        bus.buttons   = 8'h00;
        bus.nes_latch = 1'b1;
        cyc(6);
        check("live_rel", {31'd0, bus.nes_data}, 32'd1);
        bus.buttons = 8'h01;
        cyc(6);
        check("live_press", {31'd0, bus.nes_data}, 32'd0);
        bus.nes_latch = 1'b0;
        cyc(6);
        bus.buttons = 8'h00;
        cyc(6);
        check("live_held", {31'd0, bus.nes_data}, 32'd0);

        // Buttons change during SHIFT have no effect
        push_frame(8'h00);
        pulse_latch(8'h00);
        pop_check("hold_b0");
        bus.buttons = 8'hFF;
        for (int i = 1; i <= 8; i++) begin
            pulse_clk();
            pop_check($sformatf("hold_b%0d", i));
        end

        // Latch and nes_clk rising together: latch wins
        fd0 = fd_count;
        push_frame(8'h02);
        bus.buttons   = 8'h02;
        bus.nes_latch = 1'b1;
        bus.nes_clk   = 1'b1;
        cyc(6);
        bus.nes_latch = 1'b0;
        bus.nes_clk   = 1'b0;
        cyc(6);
        pop_check("sim_b0");
        for (int i = 1; i < 8; i++) begin
            pulse_clk();
            pop_check($sformatf("sim_b%0d", i));
        end
        check("sim_fd_7", fd_count, fd0);
        pulse_clk();
        pop_check("sim_end");
        check("sim_fd_8", fd_count, fd0 + 1);

        // Asynchronous reset mid-shift
        pulse_latch(8'h01);
        pulse_clk();
        #2 reset = 1'b1;
        #1;
        check("arst_data", {31'd0, bus.nes_data}, 32'd1);
        check("arst_busy", {31'd0, bus.busy}, 32'd0);
        cyc(2);
        reset = 1'b0;
        pulse_clk();
        check("arst_needs_latch", {31'd0, bus.busy}, 32'd0);

`ifdef TURBO_EN
        bus.turbo_mask = 8'h01;
        for (int f = 0; f < 8; f++) begin
            push_frame(((f % 4) < 2) ? 8'h00 : 8'h01);
            pulse_latch(8'h01);
            read_frame($sformatf("turbo_f%0d", f));
        end
`else
        bus.turbo_mask = 8'hFF;
        push_frame(8'h01);
        pulse_latch(8'h01);
        read_frame("noturbo");
`endif
        check("q_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
